// File: rtl/midi_note_parser.sv
// midi_note_parser
//   Monophonic MIDI Note On/Off decoder for a single channel. Consumes the
//   byte stream from a UART receiver, tracks running status, skips messages
//   for other channels/types, and presents the last held note to a DDS.
//
// Ports
//   CLK         system clock, rising edge
//   RESET       synchronous, active-low reset
//   BYTE_IN     received MIDI byte
//   BYTE_VALID  one-cycle strobe qualifying BYTE_IN
//   NOTE        {1'b0, key[6:0]} of the current note
//   VELOCITY    velocity of the last accepted Note On
//   GATE        high while the current note is held
//   NOTE_STB    one-cycle pulse when NOTE/VELOCITY/GATE change by a message
module midi_note_parser #(
  parameter int CHANNEL = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  output logic [7:0] NOTE,
  output logic [6:0] VELOCITY,
  output logic       GATE,
  output logic       NOTE_STB
);

  localparam logic [3:0] CH_NIB = 4'(CHANNEL);

  typedef enum logic [2:0] {
    IDLE,
    NOTE_D1,
    NOTE_D2,
    SKIP_D1,
    SKIP_D2
  } state_t;

  // Running status reduced to what decides the first data state.
  typedef enum logic [1:0] {
    RS_NONE,
    RS_NOTE,
    RS_SKIP1,
    RS_SKIP2
  } rs_t;

  state_t     state_q, state_d;
  rs_t        rs_q, rs_d;
  logic       rs_on_q, rs_on_d;     // running note status is Note On (0x9n)
  logic [6:0] key_q, key_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       stb_q, stb_d;

  logic       is_status;
  logic       is_realtime;
  logic       is_syscom;
  logic [3:0] stat_type;

  assign is_status   = BYTE_IN[7];
  assign is_realtime = (BYTE_IN[7:3] == 5'b11111);
  assign is_syscom   = (BYTE_IN[7:3] == 5'b11110);
  assign stat_type   = BYTE_IN[7:4];

  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    rs_on_d = rs_on_q;
    key_d   = key_q;
    note_d  = note_q;
    vel_d   = vel_q;
    gate_d  = gate_q;
    stb_d   = 1'b0;

    if (BYTE_VALID) begin
      if (is_realtime) begin
        // Clock/start/stop etc. are transparent to the message in progress.
        state_d = state_q;
      end else if (is_syscom) begin
        rs_d    = RS_NONE;
        state_d = IDLE;
      end else if (is_status) begin
        // Any status aborts whatever partial message was being collected.
        if ((stat_type == 4'h8 || stat_type == 4'h9) && BYTE_IN[3:0] == CH_NIB) begin
          rs_d    = RS_NOTE;
          rs_on_d = stat_type[0];
          state_d = NOTE_D1;
        end else if (stat_type == 4'hC || stat_type == 4'hD) begin
          rs_d    = RS_SKIP2;
          state_d = SKIP_D2;
        end else begin
          rs_d    = RS_SKIP1;
          state_d = SKIP_D1;
        end
      end else begin
        case (state_q)
          IDLE: state_d = IDLE;
          NOTE_D1: begin
            key_d   = BYTE_IN[6:0];
            state_d = NOTE_D2;
          end
          NOTE_D2: begin
            if (rs_on_q && BYTE_IN[6:0] != 7'd0) begin
              note_d = key_q;
              vel_d  = BYTE_IN[6:0];
              gate_d = 1'b1;
              stb_d  = 1'b1;
            end else if (gate_q && key_q == note_q) begin
              // Only releasing the sounding key closes the gate.
              gate_d = 1'b0;
              stb_d  = 1'b1;
            end
            state_d = NOTE_D1;
          end
          SKIP_D1: state_d = SKIP_D2;
          SKIP_D2: begin
            case (rs_q)
              RS_NOTE:  state_d = NOTE_D1;
              RS_SKIP1: state_d = SKIP_D1;
              RS_SKIP2: state_d = SKIP_D2;
              default:  state_d = IDLE;
            endcase
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      rs_q    <= RS_NONE;
      rs_on_q <= 1'b0;
      note_q  <= 7'h45;
      vel_q   <= 7'd0;
      gate_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rs_on_q <= rs_on_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
      gate_q  <= gate_d;
      stb_q   <= stb_d;
    end
  end

  // Key is pure data; it is always written before being used.
  always_ff @(posedge CLK) begin
    key_q <= key_d;
  end

  assign NOTE     = {1'b0, note_q};
  assign VELOCITY = vel_q;
  assign GATE     = gate_q;
  assign NOTE_STB = stb_q;

endmodule

// File: doc/midi_note_parser.md
MIDI_NOTE_PARSER -- requirements
Module: midi_note_parser

Interface
REQ-001 Parameter CHANNEL, default 0, the MIDI channel (0-15) this block responds to.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset.
REQ-004 BYTE_IN  input  8  received MIDI byte from the UART receiver.
REQ-005 BYTE_VALID  input  1  one-cycle strobe; BYTE_IN is valid when high.
REQ-006 NOTE  output  8  current note number, {0, key[6:0]}; drives note2dds_1st_gen NOTE input.
REQ-007 VELOCITY  output  7  velocity of the last accepted Note On.
REQ-008 GATE  output  1  high while the current note is held.
REQ-009 NOTE_STB  output  1  one-cycle pulse when NOTE/VELOCITY/GATE are updated by a message.

Function
REQ-010 Bytes are consumed only on cycles with BYTE_VALID=1; with BYTE_VALID=0, state and outputs hold and NOTE_STB=0.
REQ-011 Byte classes: status = bit7 set; data = bit7 clear; realtime = 0xF8-0xFF; system common = 0xF0-0xF7.
REQ-012 A realtime byte is ignored completely: no change to state, running status, partial message or outputs.
REQ-013 A system common byte clears running status and enters IDLE.
REQ-014 FSM states: IDLE, NOTE_D1, NOTE_D2, SKIP_D1, SKIP_D2.
REQ-015 Status 0x8n/0x9n with n==CHANNEL: store as running status (type and on/off), go to NOTE_D1.
REQ-016 Any other channel status (0x80-0xEF, other type or channel): store as running status; types 0xC/0xD go to SKIP_D2 (one data byte), all others go to SKIP_D1 (two data bytes).
REQ-017 A status byte received in any state aborts the partial message and is handled as in REQ-013/015/016.
REQ-018 IDLE + data byte: ignored, stays IDLE.
REQ-019 NOTE_D1 + data byte: latch key, go to NOTE_D2.
REQ-020 NOTE_D2 + data byte: execute message (REQ-022..024), then return to NOTE_D1 (running status).
REQ-021 SKIP_D1 + data -> SKIP_D2; SKIP_D2 + data -> re-enter the first data state of the running-status type (SKIP_D1, SKIP_D2 or NOTE_D1).
REQ-022 Note On with velocity 1-127: NOTE={0,key}, VELOCITY=vel, GATE=1, NOTE_STB=1 (last-note priority, monophonic).
REQ-023 Note Off, or Note On with velocity 0: if key equals NOTE[6:0] and GATE=1, GATE=0 and NOTE_STB=1; NOTE and VELOCITY unchanged; otherwise no output change and no strobe.
REQ-024 Outputs and NOTE_STB update on the same rising edge that samples the second data byte (latency one clock from that byte's BYTE_VALID).
REQ-025 NOTE_STB is never high on two consecutive cycles except for back-to-back complete messages.
REQ-026 NOTE[7] is always 0.

Reset
REQ-027 While RESET=0 at a rising edge: state=IDLE, running status cleared, NOTE=69 (0x45), VELOCITY=0, GATE=0, NOTE_STB=0.
REQ-028 Reset asserted mid-message discards the partial message; the first data byte after release is ignored (IDLE).
REQ-029 BYTE_VALID is ignored on cycles where RESET=0.

Verification
REQ-030 CHANNEL=0; bytes 0x90,0x3C,0x64 -> after third byte NOTE=0x3C, VELOCITY=0x64, GATE=1, one NOTE_STB pulse.
REQ-031 Then running status 0x40,0x50 (no status byte) -> NOTE=0x40, VELOCITY=0x50, GATE=1, NOTE_STB pulse.
REQ-032 Then 0x80,0x3C,0x00 -> no change, no strobe; then 0x90,0x40,0x00 -> GATE=0, NOTE=0x40, NOTE_STB pulse.
REQ-033 0x90,0x45,0xF8,0x7F (clock byte interleaved) -> NOTE=0x45, VELOCITY=0x7F, GATE=1; 0xF8 has no effect.
REQ-034 0x91,0x30,0x7F (channel 1) and 0xC0,0x05,0x30 -> no output change; 0x30 after 0xC0,0x05 consumed as a new program change, not a note.
REQ-035 0x90,0x3C then RESET=0 for one cycle, then 0x64 -> outputs at reset values (NOTE=69, GATE=0), no strobe.
